trace_player: RTL and testbench
===============================

# trace_player

Next-generation trace stimulus engine for BMW PIFO SRAM vPIFO benches. It accepts typed trace entries over a valid/ready stream, buffers them in a small FIFO, and replays them toward the PIFO tree as registered push, pop or push+pop commands or as idle gaps. It honours PIFO back-pressure and flags end of trace. It sits between the trace memory/loader and the PIFO top-level push/pop ports.

## Interface
- IDLECYCLE, 1024: maximum idle gap encodable; IDLECYCLE_BITS = $clog2(IDLECYCLE).
- PRIORITY_NUM, 16: priority levels; PRIORITY_BITS = $clog2(PRIORITY_NUM).
- TREE_NUM, 4: logical trees; TREE_NUM_BITS = $clog2(TREE_NUM).
- PTW, 16: payload width.
- MTW, TREE_NUM_BITS: metadata width.
- FIFO_DEPTH, 8: entry buffer depth, power of two, ≥2.
- ENTRY_BITS: derived, 2 + max(IDLECYCLE_BITS+1, PRIORITY_BITS+TREE_NUM_BITS+MTW+PTW).
- i_clk  in  1  clock.
- i_arst_n  in  1  reset, asynchronous, active-low.
- i_trace_valid  in  1  entry valid.
- i_trace_last  in  1  entry is the final one of the trace; qualified by i_trace_valid.
- i_trace_data  in  ENTRY_BITS  entry.
- o_trace_ready  out  1  entry accepted when valid&&ready.
- i_pifo_ready  in  1  PIFO can take a command this cycle.
- o_push  out  1  push strobe.
- o_push_priority  out  PRIORITY_BITS  push priority.
- o_push_tree_id  out  TREE_NUM_BITS  push tree.
- o_push_data  out  MTW+PTW  push payload.
- o_pop  out  1  pop strobe.
- o_pop_tree_id  out  TREE_NUM_BITS  pop tree.
- o_busy  out  1  FIFO non-empty, or idle gap or command in progress.
- o_done  out  1  sticky; last entry fully replayed.

## Operation
- Entry kind is bits [ENTRY_BITS-1:ENTRY_BITS-2].
  - 00 IDLE: count N in [IDLECYCLE_BITS:0].
  - 01 PUSH: {priority, tree_id, data}, LSB-aligned; data in [MTW+PTW-1:0], tree_id above it, priority above that.
  - 10 POP: tree_id in the push tree_id field.
  - 11 PUSH_POP: both operations, same tree_id, issued in one cycle.
- Ingress FIFO is FIFO_DEPTH × (ENTRY_BITS+1); the extra bit stores last.
- o_trace_ready = !full. No bypass: an entry written into an empty FIFO is visible at the head the next cycle.
- FSM states:
  - ISSUE (reset state):
    - Head is a command and i_pifo_ready=1: dequeue and register the strobes and fields.
    - Head is a command and i_pifo_ready=0: hold the head; strobes are 0.
    - Head is IDLE with N>0: dequeue, load counter=N, go to GAP.
    - Head is IDLE with N=0: dequeue, consumes one cycle, no output.
    - FIFO empty: strobes are 0.
  - GAP: decrement counter each cycle; return to ISSUE when counter is 1. An IDLE N entry therefore yields exactly N+1 cycles without issue, counting its dequeue cycle.
  - DONE: entered when the dequeued entry has last=1. For IDLE, entry occurs after its gap completes. o_done=1 and the block ignores further FIFO contents until reset.
- Idle inputs to the PIFO: priority '1, tree_id 0, data '1; pop_tree_id 0.
- Counter width is IDLECYCLE_BITS+1. N up to 2^(IDLECYCLE_BITS+1)-1 is legal; there is no wrap.

## Timing
- Reset values: o_push=0, o_pop=0, o_push_priority='1, o_push_tree_id=0, o_push_data='1, o_pop_tree_id=0, o_busy=0, o_done=0, o_trace_ready=1. FIFO is empty, FSM is in ISSUE.
- Latency: accept at cycle t → head at t+1 → strobe at t+2, provided i_pifo_ready=1 at t+1.
- Strobes are single-cycle per entry and registered. i_pifo_ready is sampled in the dequeue cycle only; a strobe already on the outputs is never withdrawn.
- Full FIFO plus a simultaneous dequeue: ready stays 0 that cycle.
- Reset mid-gap or mid-trace: all state is cleared immediately; buffered entries are lost.

## Configuration
- TRACE_PLAYER_STATS_EN defined: adds outputs o_push_cnt, o_pop_cnt and o_stall_cnt, each 32 bits.
  - PUSH_POP increments both o_push_cnt and o_pop_cnt.
  - o_stall_cnt counts cycles where the head is a command and i_pifo_ready=0.
  - All three saturate at '1 and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package trace_player_pkg holds:
  - entry-kind enum (IDLE, PUSH, POP, PUSH_POP);
  - FSM state enum (ISSUE, GAP, DONE);
  - the ENTRY_BITS derivation function.
- Sub-module trace_player_fifo: synchronous FIFO with full/empty, parameterised by width and depth.

## Test plan
- Reset, then PUSH prio 3, tree 2, data 0x55AA → one-cycle o_push at t+2 with exactly those fields; o_pop=0.
- PUSH_POP tree 1 → o_push and o_pop high in the same cycle; o_pop_tree_id=1.
- IDLE N=5 between two PUSHes → 6 cycles between the dequeue of the IDLE and the next dequeue. IDLE N=0 → 1 cycle.
- Hold i_pifo_ready=0 for 4 cycles with a POP at the head → no strobe while held, o_pop on the cycle after ready returns. Stats build: o_stall_cnt=4.
- Send 9 entries back-to-back with i_pifo_ready=0 → o_trace_ready falls after 8 accepts; no entry is lost or duplicated after release.
- Final entry is IDLE N=3 with last=1 → o_done rises after the gap and stays high. Extra entries produce no strobes. Reset clears o_done.

Source files
------------

// File: rtl/trace_player_pkg.sv
// trace_player_pkg: shared types and helpers for the trace player.
//   entry_kind_e : two-bit entry kind at the top of every trace entry
//   state_e      : replay FSM states
//   entry_bits() : trace entry width derived from the field widths
package trace_player_pkg;

    typedef enum logic [1:0] {
        KindIdle    = 2'b00,
        KindPush    = 2'b01,
        KindPop     = 2'b10,
        KindPushPop = 2'b11
    } entry_kind_e;

    typedef enum logic [1:0] {
        StIssue = 2'b00,
        StGap   = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Kind field plus the wider of the idle-count payload and the push payload.
    function automatic int unsigned entry_bits(input int unsigned idle_bits,
                                               input int unsigned prio_bits,
                                               input int unsigned tree_bits,
                                               input int unsigned mtw,
                                               input int unsigned ptw);
        int unsigned idle_w;
        int unsigned push_w;
        idle_w = idle_bits + 1;
        push_w = prio_bits + tree_bits + mtw + ptw;
        return 2 + ((idle_w > push_w) ? idle_w : push_w);
    endfunction

endpackage

// File: rtl/trace_player_fifo.sv
// trace_player_fifo: synchronous FIFO with full/empty flags, no bypass.
// Ports:
//   i_clk, i_arst_n   clock, asynchronous active-low reset (clears pointers only)
//   wr_en, wr_data    write request; ignored while full
//   rd_en             pop the head; ignored while empty
//   rd_data           current head (valid when !empty)
//   full, empty       occupancy flags
module trace_player_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_wr;
    logic        do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/trace_player.sv
// trace_player: buffers typed trace entries and replays them to a PIFO tree as
// registered push / pop / push+pop strobes or idle gaps.
// Ports:
//   i_clk, i_arst_n                       clock, asynchronous active-low reset
//   i_trace_valid/last/data, o_trace_ready entry stream (accept on valid && ready)
//   i_pifo_ready                          PIFO accepts a command this cycle
//   o_push, o_push_priority/tree_id/data  registered push command
//   o_pop, o_pop_tree_id                  registered pop command
//   o_busy                                FIFO non-empty, gap running or strobe out
//   o_done                                sticky, last entry fully replayed
// Build option TRACE_PLAYER_STATS_EN adds saturating 32-bit counters
//   o_push_cnt, o_pop_cnt, o_stall_cnt.
module trace_player
    import trace_player_pkg::*;
#(
    parameter int unsigned IDLECYCLE    = 1024,
    parameter int unsigned PRIORITY_NUM = 16,
    parameter int unsigned TREE_NUM     = 4,
    parameter int unsigned PTW          = 16,
    parameter int unsigned MTW          = $clog2(TREE_NUM),
    parameter int unsigned FIFO_DEPTH   = 8,
    localparam int unsigned IDLECYCLE_BITS = $clog2(IDLECYCLE),
    localparam int unsigned PRIORITY_BITS  = $clog2(PRIORITY_NUM),
    localparam int unsigned TREE_NUM_BITS  = $clog2(TREE_NUM),
    localparam int unsigned ENTRY_BITS     =
        entry_bits(IDLECYCLE_BITS, PRIORITY_BITS, TREE_NUM_BITS, MTW, PTW)
) (
    input  logic                      i_clk,
    input  logic                      i_arst_n,
    input  logic                      i_trace_valid,
    input  logic                      i_trace_last,
    input  logic [ENTRY_BITS-1:0]     i_trace_data,
    output logic                      o_trace_ready,
    input  logic                      i_pifo_ready,
    output logic                      o_push,
    output logic [PRIORITY_BITS-1:0]  o_push_priority,
    output logic [TREE_NUM_BITS-1:0]  o_push_tree_id,
    output logic [MTW+PTW-1:0]        o_push_data,
    output logic                      o_pop,
    output logic [TREE_NUM_BITS-1:0]  o_pop_tree_id,
    output logic                      o_busy,
    output logic                      o_done
`ifdef TRACE_PLAYER_STATS_EN
    ,
    output logic [31:0]               o_push_cnt,
    output logic [31:0]               o_pop_cnt,
    output logic [31:0]               o_stall_cnt
`endif
);

    localparam int unsigned DW = MTW + PTW;
    localparam int unsigned CW = IDLECYCLE_BITS + 1;

    // Ingress FIFO; the top bit of each slot stores the last flag.
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_BITS:0]   head;

    assign o_trace_ready = !fifo_full;
    assign fifo_wr       = i_trace_valid && !fifo_full;

    trace_player_fifo #(
        .WIDTH (ENTRY_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .wr_en    (fifo_wr),
        .wr_data  ({i_trace_last, i_trace_data}),
        .rd_en    (fifo_rd),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head field decode.
    entry_kind_e              head_kind;
    logic                     head_last;
    logic [CW-1:0]            head_n;
    logic [DW-1:0]            head_data;
    logic [TREE_NUM_BITS-1:0] head_tree;
    logic [PRIORITY_BITS-1:0] head_prio;
    logic                     head_is_push;
    logic                     head_is_pop;

    assign head_last    = head[ENTRY_BITS];
    assign head_kind    = entry_kind_e'(head[ENTRY_BITS-1 -: 2]);
    assign head_n       = head[CW-1:0];
    assign head_data    = head[DW-1:0];
    assign head_tree    = head[DW +: TREE_NUM_BITS];
    assign head_prio    = head[DW+TREE_NUM_BITS +: PRIORITY_BITS];
    assign head_is_push = (head_kind == KindPush) || (head_kind == KindPushPop);
    assign head_is_pop  = (head_kind == KindPop) || (head_kind == KindPushPop);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     gap_last_q, gap_last_d;
    logic                     push_q, push_d;
    logic                     pop_q, pop_d;
    logic [PRIORITY_BITS-1:0] prio_q, prio_d;
    logic [TREE_NUM_BITS-1:0] tree_q, tree_d;
    logic [DW-1:0]            data_q, data_d;
    logic [TREE_NUM_BITS-1:0] pop_tree_q, pop_tree_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_last_d = gap_last_q;
        fifo_rd    = 1'b0;
        // Outputs fall back to the PIFO idle values whenever nothing is issued.
        push_d     = 1'b0;
        pop_d      = 1'b0;
        prio_d     = '1;
        tree_d     = '0;
        data_d     = '1;
        pop_tree_d = '0;

        case (state_q)
            StIssue: begin
                if (!fifo_empty) begin
                    if (head_kind == KindIdle) begin
                        // Idle entries never wait on the PIFO.
                        fifo_rd = 1'b1;
                        if (head_n != '0) begin
                            cnt_d      = head_n;
                            gap_last_d = head_last;
                            state_d    = StGap;
                        end else if (head_last) begin
                            state_d = StDone;
                        end
                    end else if (i_pifo_ready) begin
                        fifo_rd = 1'b1;
                        push_d  = head_is_push;
                        pop_d   = head_is_pop;
                        if (head_is_push) begin
                            prio_d = head_prio;
                            tree_d = head_tree;
                            data_d = head_data;
                        end
                        if (head_is_pop) begin
                            pop_tree_d = head_tree;
                        end
                        if (head_last) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StGap: begin
                // The dequeue cycle plus N gap cycles gives N+1 quiet cycles.
                if (cnt_q == CW'(1)) begin
                    state_d = gap_last_q ? StDone : StIssue;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIssue;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q    <= StIssue;
            cnt_q      <= '0;
            gap_last_q <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            prio_q     <= '1;
            tree_q     <= '0;
            data_q     <= '1;
            pop_tree_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_last_q <= gap_last_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            prio_q     <= prio_d;
            tree_q     <= tree_d;
            data_q     <= data_d;
            pop_tree_q <= pop_tree_d;
        end
    end

    assign o_push          = push_q;
    assign o_pop           = pop_q;
    assign o_push_priority = prio_q;
    assign o_push_tree_id  = tree_q;
    assign o_push_data     = data_q;
    assign o_pop_tree_id   = pop_tree_q;
    // A strobe on the outputs still counts as a command in progress.
    assign o_busy          = !fifo_empty || (state_q == StGap) || push_q || pop_q;
    assign o_done          = (state_q == StDone);

`ifdef TRACE_PLAYER_STATS_EN
    logic        stall;
    logic [31:0] push_cnt_q;
    logic [31:0] pop_cnt_q;
    logic [31:0] stall_cnt_q;

    assign stall = (state_q == StIssue) && !fifo_empty && (head_kind != KindIdle) &&
                   !i_pifo_ready;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            push_cnt_q  <= '0;
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push_d && (push_cnt_q != '1)) begin
                push_cnt_q <= push_cnt_q + 32'd1;
            end
            if (pop_d && (pop_cnt_q != '1)) begin
                pop_cnt_q <= pop_cnt_q + 32'd1;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign o_push_cnt  = push_cnt_q;
    assign o_pop_cnt   = pop_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_trace_player.sv
// tb_trace_player: directed and randomized checks of trace_player against a
// command-level reference model (expected strobe list and gap timing).
module tb_trace_player;
    import trace_player_pkg::*;

    localparam int unsigned EB = entry_bits(10, 4, 2, 2, 16);

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          trace_valid = 1'b0;
    logic          trace_last = 1'b0;
    logic [EB-1:0] trace_data = '0;
    logic          trace_ready;
    logic          pifo_ready = 1'b1;
    logic          push;
    logic [3:0]    push_priority;
    logic [1:0]    push_tree_id;
    logic [17:0]   push_data;
    logic          pop;
    logic [1:0]    pop_tree_id;
    logic          busy;
    logic          done;
`ifdef TRACE_PLAYER_STATS_EN
    logic [31:0]   push_cnt;
    logic [31:0]   pop_cnt;
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    trace_player u_dut (
        .i_clk           (clk),
        .i_arst_n        (arst_n),
        .i_trace_valid   (trace_valid),
        .i_trace_last    (trace_last),
        .i_trace_data    (trace_data),
        .o_trace_ready   (trace_ready),
        .i_pifo_ready    (pifo_ready),
        .o_push          (push),
        .o_push_priority (push_priority),
        .o_push_tree_id  (push_tree_id),
        .o_push_data     (push_data),
        .o_pop           (pop),
        .o_pop_tree_id   (pop_tree_id),
        .o_busy          (busy),
        .o_done          (done)
`ifdef TRACE_PLAYER_STATS_EN
        ,
        .o_push_cnt      (push_cnt),
        .o_pop_cnt       (pop_cnt),
        .o_stall_cnt     (stall_cnt)
`endif
    );

    typedef struct packed {
        logic        push;
        logic        pop;
        logic [3:0]  prio;
        logic [1:0]  tree;
        logic [17:0] data;
        logic [1:0]  ptree;
    } rec_t;

    // kind: 0 idle, 1 push, 2 pop, 3 push+pop
    typedef struct {
        int kind;
        int prio;
        int tree;
        int data;
        int n;
        bit last;
    } cmd_t;

    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    bit   done_seen = 1'b0;
    int   done_cyc = 0;
    rec_t obs_q[$];
    int   obs_cyc[$];
    rec_t exp_q[$];

    function automatic cmd_t mk(input int kind, input int prio, input int tree,
                                input int data, input int n, input bit last);
        cmd_t c;
        c.kind = kind;
        c.prio = prio;
        c.tree = tree;
        c.data = data;
        c.n    = n;
        c.last = last;
        return c;
    endfunction

    function automatic cmd_t rand_cmd(input int kmin);
        return mk($urandom_range(kmin, 3), $urandom_range(0, 15), $urandom_range(0, 3),
                  int'($urandom & 32'h3FFFF), $urandom_range(0, 6), 1'b0);
    endfunction

    function automatic logic [EB-1:0] encode(input cmd_t c);
        logic [EB-1:0] e;
        e = '0;
        e[EB-1 -: 2] = 2'(c.kind);
        if (c.kind == 0) begin
            e[10:0] = 11'(c.n);
        end else begin
            // Pop entries also carry prio/data bits that must be ignored.
            e[17:0]  = 18'(c.data);
            e[19:18] = 2'(c.tree);
            e[23:20] = 4'(c.prio);
        end
        return e;
    endfunction

    // What the PIFO should see for one command entry.
    function automatic rec_t expect_rec(input cmd_t c);
        rec_t r;
        r.push  = (c.kind == 1) || (c.kind == 3);
        r.pop   = (c.kind == 2) || (c.kind == 3);
        r.prio  = r.push ? 4'(c.prio) : 4'hF;
        r.tree  = r.push ? 2'(c.tree) : 2'd0;
        r.data  = r.push ? 18'(c.data) : 18'h3FFFF;
        r.ptree = r.pop ? 2'(c.tree) : 2'd0;
        return r;
    endfunction

    function automatic rec_t cur_rec();
        rec_t r;
        r.push  = push;
        r.pop   = pop;
        r.prio  = push_priority;
        r.tree  = push_tree_id;
        r.data  = push_data;
        r.ptree = pop_tree_id;
        return r;
    endfunction

    always @(negedge clk) begin
        if (arst_n) begin
            cyc = cyc + 1;
            if (push || pop) begin
                obs_q.push_back(cur_rec());
                obs_cyc.push_back(cyc);
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        arst_n      = 1'b0;
        trace_valid = 1'b0;
        trace_last  = 1'b0;
        pifo_ready  = 1'b1;
        tick(2);
        arst_n    = 1'b1;
        done_seen = 1'b0;
        clear_q();
    endtask

    function automatic bit rnd_ready();
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Present one entry and return right after the edge that accepts it.
    task automatic send(input cmd_t c, input bit rnd);
        int guard;
        guard = 0;
        if (rnd) pifo_ready = rnd_ready();
        trace_valid = 1'b1;
        trace_data  = encode(c);
        trace_last  = c.last;
        while (!trace_ready && guard < 500) begin
            tick(1);
            guard++;
            if (rnd) pifo_ready = rnd_ready();
        end
        if (guard >= 500) check("send_timeout", 64'd0, 64'd1);
        tick(1);
        trace_valid = 1'b0;
        trace_last  = 1'b0;
        if (rnd) pifo_ready = rnd_ready();
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("strobe_count", 64'(obs_q.size()), 64'(n));
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check(tag, 64'(obs_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_t c;
        cmd_t b;
        cmd_t list[9];
        int   gaps[2];
`ifdef TRACE_PLAYER_STATS_EN
        int   s0;
`endif
        gaps[0] = 5;
        gaps[1] = 0;

        do_reset();

        // Reset state.
        check("rst_push", 64'(push), 64'd0);
        check("rst_pop", 64'(pop), 64'd0);
        check("rst_prio", 64'(push_priority), 64'hF);
        check("rst_tree", 64'(push_tree_id), 64'd0);
        check("rst_data", 64'(push_data), 64'h3FFFF);
        check("rst_pop_tree", 64'(pop_tree_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(trace_ready), 64'd1);

        // PUSH latency: head the cycle after accept, strobe the cycle after that.
        c = mk(1, 3, 2, 'h55AA, 0, 1'b0);
        send(c, 1'b0);
        check("lat_no_early_push", 64'(push), 64'd0);
        check("lat_busy", 64'(busy), 64'd1);
        tick(1);
        check("lat_push_fields", 64'(cur_rec()), 64'(expect_rec(c)));
        tick(1);
        check("lat_push_single", 64'(push), 64'd0);

        // PUSH_POP on tree 1 issues both strobes together.
        clear_q();
        c = mk(3, $urandom_range(0, 15), 1, int'($urandom & 32'h3FFFF), 0, 1'b0);
        send(c, 1'b0);
        wait_obs(1, 20);
        if (obs_q.size() > 0) check("push_pop_rec", 64'(obs_q[0]), 64'(expect_rec(c)));

        // Idle gaps: N+1 quiet cycles counting the idle dequeue.
        foreach (gaps[g]) begin
            clear_q();
            c = rand_cmd(1);
            b = rand_cmd(1);
            send(c, 1'b0);
            send(mk(0, 0, 0, 0, gaps[g], 1'b0), 1'b0);
            send(b, 1'b0);
            exp_q.push_back(expect_rec(c));
            exp_q.push_back(expect_rec(b));
            wait_obs(2, 50);
            compare_all("gap_rec");
            if (obs_cyc.size() == 2) begin
                check("gap_spacing", 64'(obs_cyc[1] - obs_cyc[0]), 64'(gaps[g] + 2));
            end
        end

        // Back-pressure with a POP at the head.
        clear_q();
        pifo_ready = 1'b0;
`ifdef TRACE_PLAYER_STATS_EN
        s0 = int'(stall_cnt);
`endif
        c = mk(2, 9, 3, 'h1234, 0, 1'b0);
        send(c, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("hold_no_pop", 64'(pop), 64'd0);
            tick(1);
        end
        pifo_ready = 1'b1;
        check("hold_no_pop_release", 64'(pop), 64'd0);
        tick(1);
        check("hold_pop_rec", 64'(cur_rec()), 64'(expect_rec(c)));
`ifdef TRACE_PLAYER_STATS_EN
        check("stall_cnt", 64'(int'(stall_cnt) - s0), 64'd4);
`endif

        // Fill the FIFO with the PIFO stalled.
        tick(2);
        clear_q();
        pifo_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            list[i] = rand_cmd(1);
            exp_q.push_back(expect_rec(list[i]));
        end
        for (int i = 0; i < 8; i++) send(list[i], 1'b0);
        check("fill_ready_low", 64'(trace_ready), 64'd0);
        trace_valid = 1'b1;
        trace_data  = encode(list[8]);
        tick(3);
        check("fill_ready_held", 64'(trace_ready), 64'd0);
        check("fill_no_strobe", 64'(obs_q.size()), 64'd0);
        pifo_ready = 1'b1;
        check("fill_ready_dequeue_cycle", 64'(trace_ready), 64'd0);
        send(list[8], 1'b0);
        wait_obs(9, 100);
        compare_all("fill_rec");
        tick(5);
        check("fill_no_extra", 64'(obs_q.size()), 64'd9);

        // Randomized traffic against the command-order model.
        clear_q();
        for (int i = 0; i < 60; i++) begin
            c = rand_cmd(0);
            if (c.kind != 0) exp_q.push_back(expect_rec(c));
            send(c, 1'b1);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        pifo_ready = 1'b1;
        wait_obs(exp_q.size(), 2000);
        compare_all("rand_rec");
        tick(3);
        check("rand_no_extra", 64'(obs_q.size()), 64'(exp_q.size()));

        // Final IDLE N=3 with last: done after the gap, then sticky.
        tick(10);
        clear_q();
        done_seen = 1'b0;
        c = rand_cmd(1);
        send(c, 1'b0);
        send(mk(0, 0, 0, 0, 3, 1'b1), 1'b0);
        for (int k = 0; k < 30 && !done_seen; k++) tick(1);
        check("done_seen", 64'(done_seen), 64'd1);
        if (obs_cyc.size() == 1) check("done_timing", 64'(done_cyc - obs_cyc[0]), 64'd4);
        send(rand_cmd(1), 1'b0);
        send(rand_cmd(1), 1'b0);
        tick(10);
        check("done_no_strobes", 64'(obs_q.size()), 64'd1);
        check("done_sticky", 64'(done), 64'd1);

        do_reset();
        check("reset_clears_done", 64'(done), 64'd0);
        check("reset_ready", 64'(trace_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);

        // Reset in the middle of a long gap.
        send(mk(0, 0, 0, 0, 50, 1'b0), 1'b0);
        tick(3);
        check("gap_busy", 64'(busy), 64'd1);
        do_reset();
        check("midgap_reset_busy", 64'(busy), 64'd0);
        c = rand_cmd(1);
        send(c, 1'b0);
        wait_obs(1, 20);
        if (obs_q.size() > 0) check("after_reset_rec", 64'(obs_q[0]), 64'(expect_rec(c)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
